asteroid_director: RTL and testbench

Control stage directly upstream of each `asteroid` instance; it is also the consumer of that instance's `broken` output.
- Generates the per-frame `move` strobe and classifies collisions into `break_conditions` from pixel-overlap flags gathered during the active frame.
- Runs score/lives bookkeeping on each break, and respawns the asteroid after a frame-count delay via `unbreak` plus a pseudo-random `spawn_x` from an internal LFSR.

---
 rtl/asteroid_director.sv | 166 ++++++++++++++++
 tb/tb_asteroid_director.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/asteroid_director.sv
// asteroid_director
// Control stage sitting in front of one asteroid instance. It issues the
// per-frame move strobe, classifies what hit the asteroid during the visible
// frame, keeps score/lives, and respawns the asteroid at a pseudo-random
// column after a frame-count delay.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   pixpulse           pixel-rate enable; every state change waits for it
//   hcount, vcount     current raster position
//   draw_ast           asteroid covers the current pixel
//   bullet_pix         a bullet covers the current pixel
//   ship_pix           the ship covers the current pixel
//   ast_broken         asteroid's broken flag
//   move               one-pixpulse frame strobe
//   break_conditions   00 end of screen, 01 bullet hit, 10 ship hit
//   unbreak            one-pixpulse respawn strobe
//   spawn_load         coincident with unbreak, spawn_x valid
//   spawn_x            respawn column
//   score              bullet kills, saturating at 255
//   lives              remaining lives, saturating at 0
//   game_over          sticky once lives reach 0
//
// state | meaning
// ALIVE | asteroid in play, waiting for a break
// WAIT  | asteroid broken, counting frames down to respawn
// SPAWN | respawn strobe cycle
// OVER  | no lives left, terminal until reset

module asteroid_director #(
   parameter int unsigned V_ACTIVE       = 480,
   parameter int unsigned RESPAWN_FRAMES = 60,
   parameter int unsigned XMIN           = 64,
   parameter logic [9:0]  LFSR_SEED      = 10'h2A5,
   parameter int unsigned START_LIVES    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pixpulse,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       draw_ast,
   input  logic       bullet_pix,
   input  logic       ship_pix,
   input  logic       ast_broken,
   output logic       move,
   output logic [1:0] break_conditions,
   output logic       unbreak,
   output logic       spawn_load,
   output logic [9:0] spawn_x,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic       game_over
);

   typedef enum logic [1:0] {ALIVE, WAIT, SPAWN, OVER} state_t;

   localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
   localparam logic [7:0] RESPAWN = 8'(RESPAWN_FRAMES);
   localparam logic [9:0] X_LO    = 10'(XMIN);
   localparam logic [1:0] LIVES0  = 2'(START_LIVES);

   state_t     state;
   logic [7:0] cnt;
   logic [9:0] lfsr;
   logic       hit_b;
   logic       hit_s;
   logic       brk_q;

   logic       ft;
   logic       brk_ev;
   logic [1:0] lives_dec;
   logic       ship_kill;

   assign ft        = pixpulse && (hcount == 10'd0) && (vcount == V_ACT);
   assign brk_ev    = pixpulse && ast_broken && !brk_q;
   assign lives_dec = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
   // A ship break that uses up the last life ends the game from any state.
   assign ship_kill = brk_ev && (break_conditions == 2'b10) && (lives_dec == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ALIVE;
         cnt              <= 8'd0;
         lfsr             <= LFSR_SEED;
         hit_b            <= 1'b0;
         hit_s            <= 1'b0;
         brk_q            <= 1'b0;
         move             <= 1'b0;
         break_conditions <= 2'b00;
         unbreak          <= 1'b0;
         spawn_load       <= 1'b0;
         spawn_x          <= X_LO;
         score            <= 8'd0;
         lives            <= LIVES0;
         game_over        <= 1'b0;
      end else if (pixpulse) begin
         move  <= ft;
         lfsr  <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
         brk_q <= ast_broken;

         if (ft) begin
            // ship wins over bullet when both touched the asteroid this frame
            if (hit_s)
               break_conditions <= 2'b10;
            else if (hit_b)
               break_conditions <= 2'b01;
            else
               break_conditions <= 2'b00;
            hit_b <= 1'b0;
            hit_s <= 1'b0;
         end else if (vcount < V_ACT) begin
            if (draw_ast && bullet_pix)
               hit_b <= 1'b1;
            if (draw_ast && ship_pix)
               hit_s <= 1'b1;
         end

         // Bookkeeping uses the classification from the previous frame, even
         // when the break lands on the frame tick itself.
         if (brk_ev) begin
            if (break_conditions == 2'b01 && score != 8'hFF)
               score <= score + 8'd1;
            if (break_conditions == 2'b10) begin
               lives <= lives_dec;
               if (lives_dec == 2'd0)
                  game_over <= 1'b1;
            end
         end

         unbreak    <= 1'b0;
         spawn_load <= 1'b0;

         case (state)
            ALIVE: begin
               if (ship_kill)
                  state <= OVER;
               else if (brk_ev) begin
                  cnt   <= RESPAWN;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (ship_kill)
                  state <= OVER;
               else if (cnt == 8'd0) begin
                  state      <= SPAWN;
                  unbreak    <= 1'b1;
                  spawn_load <= 1'b1;
                  spawn_x    <= X_LO + {1'b0, lfsr[8:0]};
               end else if (ft)
                  cnt <= cnt - 8'd1;
            end
            SPAWN: begin
               if (ship_kill)
                  state <= OVER;
               else
                  state <= ALIVE;
            end
            OVER: state <= OVER;
            default: state <= ALIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_asteroid_director.sv
module tb_asteroid_director;

   localparam int         XMIN = 64;
   localparam logic [9:0] SEED = 10'h2A5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pixpulse = 1'b0;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = '0;
   logic       draw_ast = 1'b0;
   logic       bullet_pix = 1'b0;
   logic       ship_pix = 1'b0;
   logic       ast_broken = 1'b0;
   logic       move;
   logic [1:0] break_conditions;
   logic       unbreak;
   logic       spawn_load;
   logic [9:0] spawn_x;
   logic [7:0] score;
   logic [1:0] lives;
   logic       game_over;

   asteroid_director dut (
      .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
      .draw_ast(draw_ast), .bullet_pix(bullet_pix), .ship_pix(ship_pix),
      .ast_broken(ast_broken), .move(move), .break_conditions(break_conditions),
      .unbreak(unbreak), .spawn_load(spawn_load), .spawn_x(spawn_x),
      .score(score), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [9:0] m_lfsr = SEED;
   logic [9:0] m_prev = SEED;

   typedef struct {
      logic       pp;
      logic [9:0] h;
      logic [9:0] v;
      logic       da, bp, sp, ab;
      logic       mv;
      logic [1:0] bc;
      logic       ub;
      logic [7:0] sc;
      logic [1:0] lv;
      logic       go;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // one clk edge; outputs are looked at 1ns after it
   task automatic tick();
      @(posedge clk);
      #1;
      if (pixpulse) begin
         m_prev = m_lfsr;
         m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      end
   endtask

   task automatic pix(input logic [9:0] h, input logic [9:0] v,
                      input logic da, input logic bp, input logic sp, input logic ab);
      pixpulse = 1'b1; hcount = h; vcount = v;
      draw_ast = da; bullet_pix = bp; ship_pix = sp; ast_broken = ab;
      tick();
   endtask

   task automatic ft(input logic ab);
      pix(10'd0, 10'd480, 1'b0, 1'b0, 1'b0, ab);
   endtask

   task automatic idle();
      pixpulse = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; pixpulse = 1'b0; hcount = '0; vcount = '0;
      draw_ast = 1'b0; bullet_pix = 1'b0; ship_pix = 1'b0; ast_broken = 1'b0;
      m_lfsr = SEED;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int ub_cnt;
      int mv_cnt;
      int zero_cnt;
      int early_cnt;
      logic [9:0] exp_x;

      //            pp  h    v    da bp sp ab  mv bc ub sc lv go
      tbl[0]  = '{1, 300, 200, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0};
      tbl[1]  = '{0,   0, 480, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
      tbl[2]  = '{1,   0, 480, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0};
      tbl[3]  = '{0,   5, 480, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0};
      tbl[4]  = '{1,   1, 480, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0};
      tbl[5]  = '{1,   2, 480, 0, 0, 0, 1, 0, 1, 0, 1, 3, 0};
      tbl[6]  = '{1,   3, 480, 0, 0, 0, 1, 0, 1, 0, 1, 3, 0};
      tbl[7]  = '{1,  10,  10, 1, 1, 1, 1, 0, 1, 0, 1, 3, 0};
      tbl[8]  = '{1,   0, 480, 0, 0, 0, 1, 1, 2, 0, 1, 3, 0};
      tbl[9]  = '{1,   1, 480, 0, 0, 0, 0, 0, 2, 0, 1, 3, 0};
      tbl[10] = '{1,   2, 480, 0, 0, 0, 1, 0, 2, 0, 1, 2, 0};
      tbl[11] = '{1,   0, 480, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0};
      tbl[12] = '{1,   1, 480, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0};
      tbl[13] = '{1,   1, 480, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0};
      tbl[14] = '{1,   5, 481, 1, 1, 0, 1, 0, 0, 0, 1, 2, 0};
      tbl[15] = '{1,   0, 480, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0};

      // reset values while rst is held
      rst = 1'b1;
      tick();
      chk("rst_move", move, 0);
      chk("rst_unbreak", unbreak, 0);
      chk("rst_spawn_load", spawn_load, 0);
      chk("rst_bc", break_conditions, 0);
      chk("rst_spawn_x", spawn_x, XMIN);
      chk("rst_score", score, 0);
      chk("rst_lives", lives, 3);
      chk("rst_game_over", game_over, 0);
      do_reset();

      for (int i = 0; i < 16; i++) begin
         pixpulse = tbl[i].pp; hcount = tbl[i].h; vcount = tbl[i].v;
         draw_ast = tbl[i].da; bullet_pix = tbl[i].bp; ship_pix = tbl[i].sp;
         ast_broken = tbl[i].ab;
         tick();
         chk($sformatf("vec%0d_move", i), move, tbl[i].mv);
         chk($sformatf("vec%0d_bc", i), break_conditions, tbl[i].bc);
         chk($sformatf("vec%0d_unbreak", i), unbreak, tbl[i].ub);
         chk($sformatf("vec%0d_score", i), score, tbl[i].sc);
         chk($sformatf("vec%0d_lives", i), lives, tbl[i].lv);
         chk($sformatf("vec%0d_game_over", i), game_over, tbl[i].go);
      end

      // asynchronous reset in the middle of a move strobe and of WAIT
      ft(1'b1);
      chk("pre_arst_move", move, 1);
      pixpulse = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_move", move, 0);
      chk("arst_score", score, 0);
      chk("arst_lives", lives, 3);
      chk("arst_bc", break_conditions, 0);
      #1 rst = 1'b0;
      ast_broken = 1'b0;
      m_lfsr = SEED;
      ft(1'b0);
      chk("post_arst_move", move, 1);
      pix(10'd1, 10'd480, 0, 0, 0, 0);
      chk("post_arst_move_low", move, 0);

      // bullet kill and respawn timing
      do_reset();
      pix(10'd300, 10'd200, 1, 1, 0, 0);
      ft(1'b0);
      pix(10'd1, 10'd480, 0, 0, 0, 1);
      chk("kill_bc", break_conditions, 1);
      chk("kill_score", score, 1);
      ub_cnt = 0;
      for (int f = 1; f <= 60; f++) begin
         ft(1'b1);
         if (unbreak) ub_cnt++;
         if (f < 60) begin
            pix(10'd2, 10'd480, 0, 0, 0, 1);
            if (unbreak) ub_cnt++;
         end
      end
      chk("early_unbreak", ub_cnt, 0);
      pix(10'd3, 10'd480, 0, 0, 0, 1);
      exp_x = 10'(XMIN) + {1'b0, m_prev[8:0]};
      chk("spawn_unbreak", unbreak, 1);
      chk("spawn_load", spawn_load, 1);
      chk("spawn_x", spawn_x, exp_x);
      chk("spawn_x_range", (spawn_x >= 10'd64 && spawn_x <= 10'd575), 1);
      idle();
      chk("unbreak_hold_no_pixpulse", unbreak, 1);
      pix(10'd4, 10'd480, 0, 0, 0, 0);
      chk("unbreak_low", unbreak, 0);
      chk("spawn_load_low", spawn_load, 0);
      chk("spawn_x_hold", spawn_x, exp_x);

      // three ship breaks, ship wins over bullet in the same frame
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         pix(10'd10, 10'd10, 1, 1, 1, 0);
         ft(1'b0);
         chk($sformatf("ship%0d_bc", k), break_conditions, 2);
         pix(10'd1, 10'd480, 0, 0, 0, 1);
         chk($sformatf("ship%0d_lives", k), lives, 3 - k);
         chk($sformatf("ship%0d_score", k), score, 0);
         chk($sformatf("ship%0d_game_over", k), game_over, (k == 3) ? 1 : 0);
         pix(10'd2, 10'd480, 0, 0, 0, 0);
      end
      ub_cnt = 0;
      mv_cnt = 0;
      for (int f = 0; f < 100; f++) begin
         ft(1'b0);
         if (move) mv_cnt++;
         if (unbreak) ub_cnt++;
         pix(10'd1, 10'd480, 0, 0, 0, 0);
         if (unbreak) ub_cnt++;
      end
      chk("over_move_count", mv_cnt, 100);
      chk("over_no_unbreak", ub_cnt, 0);
      pix(10'd10, 10'd10, 1, 0, 1, 0);
      ft(1'b0);
      pix(10'd1, 10'd480, 0, 0, 0, 1);
      chk("over_lives_sat", lives, 0);
      chk("over_game_over", game_over, 1);

      // score saturation
      do_reset();
      pix(10'd300, 10'd200, 1, 1, 0, 0);
      ft(1'b0);
      for (int n = 1; n <= 256; n++) begin
         pix(10'd1, 10'd480, 0, 0, 0, 1);
         if (n == 254) chk("score_254", score, 254);
         if (n == 255) chk("score_255", score, 255);
         pix(10'd2, 10'd480, 0, 0, 0, 0);
      end
      chk("score_saturated", score, 255);

      // ast_broken held high across 10 bullet frames counts once
      do_reset();
      pix(10'd300, 10'd200, 1, 1, 0, 0);
      ft(1'b0);
      pix(10'd1, 10'd480, 0, 0, 0, 1);
      for (int f = 0; f < 10; f++) begin
         pix(10'd300, 10'd200, 1, 1, 0, 1);
         ft(1'b1);
      end
      chk("held_bc", break_conditions, 1);
      chk("held_score", score, 1);

      // LFSR period
      do_reset();
      zero_cnt = 0;
      early_cnt = 0;
      for (int i = 1; i <= 1023; i++) begin
         pix(10'd5, 10'd5, 0, 0, 0, 0);
         if (i == 1) chk("lfsr_step1", dut.lfsr, 10'h14B);
         if (dut.lfsr == 10'd0) zero_cnt++;
         if (i < 1023 && dut.lfsr == SEED) early_cnt++;
      end
      chk("lfsr_never_zero", zero_cnt, 0);
      chk("lfsr_no_early_repeat", early_cnt, 0);
      chk("lfsr_period", dut.lfsr, SEED);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
